// File: rtl/signal_interval_tracker.sv
// Per-cycle history of a tracked signal and its handshake, stamped with the cycle counter.
// A search looks back over a window and reports the first activity interval past a boundary.
module signal_interval_tracker #(
  parameter int unsigned SIGNAL_WIDTH = 1,
  parameter int unsigned CORROB_WIDTH = 1,
  parameter int unsigned BUFFER_SIZE  = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [31:0]      counter,
  input  logic [SIGNAL_WIDTH-1:0] tracked_signal,
  input  logic [CORROB_WIDTH-1:0] corroborating_signal,
  input  logic signed [31:0]      value_in,
  input  logic                    recalculate_time,
  input  logic                    update_end,
  input  logic signed [31:0]      previous_end_i,
  output logic signed [31:0]      time_out [1:0]
);

  localparam int unsigned AW = $clog2(BUFFER_SIZE);

  logic signed [31:0]     ts_mem [BUFFER_SIZE];
  logic [BUFFER_SIZE-1:0] trk_mem;
  logic [BUFFER_SIZE-1:0] cor_mem;

  logic [AW-1:0]      wr_q;
  logic [AW:0]        cnt_q;
  logic signed [31:0] bound_q;
  logic signed [31:0] start_q, start_d;
  logic signed [31:0] end_q, end_d;

  // History storage needs no reset; the valid count guards stale entries.
  always_ff @(posedge clk) begin
    ts_mem[wr_q]  <= counter;
    trk_mem[wr_q] <= |tracked_signal;
    cor_mem[wr_q] <= |corroborating_signal;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      cnt_q   <= '0;
      bound_q <= -32'sd1;
      start_q <= -32'sd1;
      end_q   <= -32'sd1;
    end else begin
      wr_q <= wr_q + 1'b1;
      if (cnt_q != (AW+1)'(BUFFER_SIZE)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (update_end) begin
        bound_q <= previous_end_i;
      end
      if (recalculate_time) begin
        start_q <= start_d;
        end_q   <= end_d;
      end
    end
  end

  logic signed [31:0] bound_eff, win_lo, win_hi, ts;
  logic [AW-1:0]      oldest, idx;
  logic               in_win, found_s, found_e;

  // Oldest-first priority scan; start and end are found in one pass.
  always_comb begin
    bound_eff = update_end ? previous_end_i : bound_q;
    win_lo    = counter - value_in;
    win_hi    = counter - 32'sd1;
    oldest    = wr_q - cnt_q[AW-1:0];
    idx       = '0;
    ts        = '0;
    in_win    = 1'b0;
    found_s   = 1'b0;
    found_e   = 1'b0;
    start_d   = -32'sd1;
    end_d     = -32'sd1;
    for (int k = 0; k < BUFFER_SIZE; k++) begin
      idx    = oldest + AW'(k);
      ts     = ts_mem[idx];
      in_win = ((AW+1)'(k) < cnt_q) && (value_in > 0) && (ts >= win_lo) && (ts <= win_hi);
      if (in_win) begin
        if (!found_s && trk_mem[idx] && (ts > bound_eff)) begin
          found_s = 1'b1;
          start_d = ts;
        end
        if (found_s && !found_e) begin
          if (trk_mem[idx] && cor_mem[idx]) begin
            found_e = 1'b1;
            end_d   = ts;
          end else if (!trk_mem[idx]) begin
            found_e = 1'b1;
            end_d   = ts - 32'sd1;
          end
        end
      end
    end
  end

  assign time_out[0] = start_q;
  assign time_out[1] = end_q;

endmodule

// File: tb/tb_signal_interval_tracker.sv
// Directed-vector bench for signal_interval_tracker with hand-computed interval results.
module tb_signal_interval_tracker;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [31:0] counter = '0;
  logic [0:0]         tracked_signal = '0;
  logic [0:0]         corroborating_signal = '0;
  logic signed [31:0] value_in = '0;
  logic               recalculate_time = 1'b0;
  logic               update_end = 1'b0;
  logic signed [31:0] previous_end_i = '0;
  logic signed [31:0] time_out [1:0];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  signal_interval_tracker #(
    .SIGNAL_WIDTH(1),
    .CORROB_WIDTH(1),
    .BUFFER_SIZE (128)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .counter             (counter),
    .tracked_signal      (tracked_signal),
    .corroborating_signal(corroborating_signal),
    .value_in            (value_in),
    .recalculate_time    (recalculate_time),
    .update_end          (update_end),
    .previous_end_i      (previous_end_i),
    .time_out            (time_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_pair(input string tag, input int exp_s, input int exp_e);
    check_val({tag, ".start"}, time_out[0], exp_s);
    check_val({tag, ".end"}, time_out[1], exp_e);
  endtask

  // One clock: drive inputs for the edge stamped cyc, then sample 1ns after it.
  task automatic run_cycle(input logic trk, input logic cor, input logic rc, input logic ue,
                           input int vi, input int pe);
    counter              = cyc;
    tracked_signal       = trk;
    corroborating_signal = cor;
    recalculate_time     = rc;
    update_end           = ue;
    value_in             = vi;
    previous_end_i       = pe;
    @(posedge clk);
    #1;
    cyc++;
    recalculate_time = 1'b0;
    update_end       = 1'b0;
  endtask

  task automatic do_reset();
    rst              = 1'b0;
    recalculate_time = 1'b0;
    update_end       = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // Complete interval ending on ready, plus window/boundary variations.
    do_reset();
    check_pair("reset", -1, -1);
    for (int c = 0; c <= 20; c++) begin
      run_cycle(c >= 10 && c <= 13, c == 13, c == 20, 1'b0, 15, 0);
    end
    check_pair("end_on_ready", 10, 13);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 9, 0);     // window 12..20
    check_pair("narrow_window", 12, 13);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 13);    // boundary update alone
    check_pair("hold_on_update", 12, 13);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    check_pair("zero_window", -1, -1);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 20, 0);    // boundary 13 excludes all
    check_pair("boundary_blocks", -1, -1);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 30, 9);    // same-edge boundary 9
    check_pair("same_edge_bound", 10, 13);
    #2;
    rst = 1'b0;
    #1;
    check_pair("async_reset", -1, -1);

    // Complete interval ending on drop.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      run_cycle(c >= 5 && c <= 7, 1'b0, c == 12, 1'b0, 10, 0);
    end
    check_pair("end_on_drop", 5, 7);

    // Boundary exclusion.
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      run_cycle((c >= 10 && c <= 13) || (c >= 15 && c <= 16), c == 13 || c == 16,
                c == 20, c == 14, 15, 13);
    end
    check_pair("boundary_excl", 15, 16);

    // Open interval, then not found after reset.
    do_reset();
    for (int c = 0; c <= 35; c++) begin
      run_cycle(c >= 30, 1'b0, c == 35, 1'b0, 10, 0);
    end
    check_pair("open_interval", 30, -1);
    do_reset();
    check_pair("reset_again", -1, -1);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 10, 0);
    check_pair("empty_history", -1, -1);

    // Wrap-around: history far longer than the buffer.
    do_reset();
    for (int c = 0; c <= 302; c++) begin
      run_cycle(c == 300, c == 300, c == 302, 1'b0, 400, 0);
    end
    check_pair("wrap_around", 300, 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
